// File: rtl/apb_master_interface.sv
// APB requester: turns valid/ready commands into APB SETUP/ACCESS transfers with a one-cycle response pulse.
// Optional ACCESS timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_interface #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("apb_master_interface: TIMEOUT_CYCLES must be in 1..255");
   end

   assign cmd_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
   localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT_CYCLES);

   logic [7:0] tcnt;
   logic       tmo_r;
   logic       tcnt_limit;

   // True when this wait edge would bring the counter up to the limit.
   assign tcnt_limit  = (({1'b0, tcnt} + 9'd1) == TO_LIMIT);
   assign rsp_timeout = tmo_r;
`else
   assign rsp_timeout = 1'b0;
`endif

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         tcnt      <= '0;
         tmo_r     <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  pwrite  <= cmd_write;
                  paddr   <= cmd_addr;
                  pwdata  <= cmd_wdata;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
               tcnt    <= '0;
`endif
            end
            ACCESS: begin
               if (pready) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= pwrite ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
                  tmo_r     <= 1'b0;
`endif
                  state     <= IDLE;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (tcnt_limit) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  tmo_r     <= 1'b1;
                  state     <= IDLE;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
`endif
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_interface.sv
// Self-checking bench for apb_master_interface: directed cases plus randomized transfers against a timeline/memory model.
module tb_apb_master_interface;

   localparam int unsigned TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        pclk;
   logic        presetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_timeout;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [31:0] last_rd = '0;
   logic [31:0] mem [logic [31:0]];

   apb_master_interface #(.TIMEOUT_CYCLES(TO)) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   function automatic logic [31:0] slave_lookup(input logic [31:0] addr);
      if (mem.exists(addr)) return mem[addr];
      return addr ^ 32'h5A5A_0000;
   endfunction

   task automatic idle_tick;
      tick;
      check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("idle_psel", {31'd0, psel}, 32'd0);
      check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("idle_rdata_hold", rsp_rdata, last_rd);
   endtask

   // One complete transfer, starting in a cycle where the master is idle.
   // waits = number of ACCESS edges the slave holds pready low.
   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned waits, input bit hold);
      logic [31:0] rd_val;
      logic [31:0] exp_rd;
      bit          to;
      int unsigned acc;
      to     = TO_EN && (waits >= TO);
      acc    = to ? TO : waits + 1;
      rd_val = slave_lookup(addr);
      exp_rd = (wr || to) ? 32'd0 : rd_val;

      check("pre_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      pready    = 1'($urandom);
      prdata    = $urandom;
      tick;
      check("setup_psel", {31'd0, psel}, 32'd1);
      check("setup_penable", {31'd0, penable}, 32'd0);
      check("setup_pwrite", {31'd0, pwrite}, {31'd0, wr});
      check("setup_paddr", paddr, addr);
      check("setup_pwdata", pwdata, wdata);
      check("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("setup_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      if (hold) begin
         cmd_write = 1'($urandom);
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
      end else begin
         cmd_valid = 1'b0;
      end
      pready = 1'($urandom);
      prdata = $urandom;
      for (int unsigned j = 0; j < acc; j++) begin
         tick;
         check("access_psel", {31'd0, psel}, 32'd1);
         check("access_penable", {31'd0, penable}, 32'd1);
         check("access_pwrite", {31'd0, pwrite}, {31'd0, wr});
         check("access_paddr", paddr, addr);
         check("access_pwdata", pwdata, wdata);
         check("access_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         check("access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         pready = (j == waits);
         prdata = pready ? rd_val : $urandom;
      end
      tick;
      check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, to});
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_psel", {31'd0, psel}, 32'd0);
      check("rsp_penable", {31'd0, penable}, 32'd0);
      check("rsp_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rsp_paddr_hold", paddr, addr);
      if (wr && !to) mem[addr] = wdata;
      last_rd   = exp_rd;
      cmd_valid = 1'b0;
      pready    = 1'b0;
   endtask

   initial begin
      presetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      prdata    = '0;
      pready    = 1'b0;
      tick;
      tick;
      check("rst_psel", {31'd0, psel}, 32'd0);
      check("rst_penable", {31'd0, penable}, 32'd0);
      check("rst_pwrite", {31'd0, pwrite}, 32'd0);
      check("rst_paddr", paddr, 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      presetn = 1'b1;
      idle_tick;

      // Zero-wait write
      do_xfer(1'b1, 32'h0000_0004, 32'hA5A5_1234, 0, 1'b0);
      idle_tick;

      // Read with two wait states
      mem[32'h0000_0008] = 32'h0000_0001;
      do_xfer(1'b0, 32'h0000_0008, 32'h0, 2, 1'b0);
      idle_tick;
      idle_tick;

      // Back-to-back with cmd_valid held
      for (int unsigned k = 0; k < 4; k++)
         do_xfer(k[0], 32'h0000_0100 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), 0, 1'b1);
      idle_tick;

      // Long stall: times out when the timeout is built in, completes otherwise
      do_xfer(1'b0, 32'h0000_0008, 32'h0, 100, 1'b0);
      idle_tick;

      // Limit boundary: pready on the same edge the counter would hit the limit
      do_xfer(1'b0, 32'h0000_0004, 32'h0, TO - 1, 1'b0);
      do_xfer(1'b1, 32'h0000_000C, 32'h1357_9BDF, TO, 1'b0);
      idle_tick;

      // Randomized traffic
      for (int unsigned n = 0; n < 30; n++) begin
         do_xfer(1'($urandom), {27'd0, 3'($urandom_range(0, 7)), 2'b00}, $urandom,
                 $urandom_range(0, 5), 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            for (int unsigned g = 0; g < $urandom_range(1, 2); g++) idle_tick;
         end
      end
      idle_tick;

      // Asynchronous reset in the middle of ACCESS
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0010;
      cmd_wdata = 32'hFFFF_0000;
      tick;
      cmd_valid = 1'b0;
      pready    = 1'b0;
      tick;
      check("pre_rst_penable", {31'd0, penable}, 32'd1);
      #2;
      presetn = 1'b0;
      #1;
      check("arst_psel", {31'd0, psel}, 32'd0);
      check("arst_penable", {31'd0, penable}, 32'd0);
      check("arst_paddr", paddr, 32'd0);
      check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_addr  = 32'h0000_0020;
      tick;
      check("inrst_psel", {31'd0, psel}, 32'd0);
      check("inrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      presetn = 1'b1;
      last_rd = '0;
      do_xfer(1'b0, 32'h0000_0010, 32'h0, 1, 1'b0);
      idle_tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
